data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 38 +++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory responder.
package dmem_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port and a registered read port.
// Contents are never reset. Only the read register is reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rd_clr zeroes the register for store and error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed wait states.
// Optional macro DMEM_MISALIGN_ERR_EN flags req_addr[1:0] != 0 as an error.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [AW-1:0]     lat_idx;
    logic [WORD_W-1:0] lat_wdata;

    logic              accept;
    logic              to_resp;
    logic              cur_write;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;
    logic              mem_we;
    logic              rd_en;
    logic              rd_clr;
    logic              addr_unused;

    assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    logic lat_mis;
`endif

    // Access happens on entry to RESP. With zero wait states that entry is
    // the accept edge itself, so the live request fields are used directly.
    always_comb begin
        accept    = req_valid && req_ready;
        cur_write = (state == IDLE) ? req_write : lat_write;
        cur_idx   = (state == IDLE) ? req_addr[AW+1:2] : lat_idx;
        cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
        cur_err   = (state == IDLE) ? (req_addr[1:0] != 2'b00) : lat_mis;
`else
        cur_err   = 1'b0;
`endif
        // The counter counts down during WAIT. Leaving WAIT when the decremented
        // value reaches zero gives accept-to-response latency of WAIT_CYCLES+1.
        to_resp   = (accept && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt <= CNT_W'(1)));
        mem_we    = to_resp && cur_write && !cur_err;
        rd_en     = to_resp && !cur_write && !cur_err;
        rd_clr    = to_resp && (cur_write || cur_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
            lat_mis   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_idx   <= req_addr[AW+1:2];
                        lat_wdata <= req_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
                        lat_mis   <= (req_addr[1:0] != 2'b00);
`endif
                        req_ready <= 1'b0;
                        if (to_resp) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= cur_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (to_resp) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cur_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .addr   (cur_idx),
        .wdata  (cur_wdata),
        .rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES 2 and 0), vector table plus scoreboard.
module tb_data_mem_responder;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          which;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs [16];
    exp_t sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int which, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat, input int hold);
        vec_t v;
        v.which = which; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.hold = hold;
        return v;
    endfunction

    // One request/response; during hold cycles a conflicting store is presented and must be ignored.
    task automatic run_txn(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        int   w;
        logic [31:0] snap;
        w = v.which;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready[w]), 32'd1);
        req_valid[w] = 1'b1;
        req_write    = v.wr;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sbq.push_back(e);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        lat = 1;
        while (!rsp_valid[w] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sbq.pop_front();
        if (!rsp_valid[w]) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no rsp_valid expected within %0d cycles", tag, got.lat);
            return;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
        snap = rsp_rdata[w];
        for (int h = 0; h < v.hold; h++) begin
            req_valid[w] = 1'b1;
            req_write    = 1'b1;
            req_wdata    = 32'hBAD0_0BAD;
            @(posedge clk); #1;
            chk($sformatf("%s_hold%0d_valid", tag, h), 32'(rsp_valid[w]), 32'd1);
            chk($sformatf("%s_hold%0d_rdata", tag, h), rsp_rdata[w], snap);
            chk($sformatf("%s_hold%0d_ready", tag, h), 32'(req_ready[w]), 32'd0);
        end
        @(negedge clk);
        req_valid[w] = 1'b0;
        chk({tag, "_rdata"}, rsp_rdata[w], got.rdata);
        chk({tag, "_err"}, 32'(rsp_err[w]), 32'(got.err));
        rsp_ready[w] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[w] = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid[w]), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready[w]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200us");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(0, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 3, 0);
        vecs[1]  = mk(0, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0);
        vecs[2]  = mk(0, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 3, 5);
        vecs[3]  = mk(0, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0);
        vecs[4]  = mk(0, 1'b1, 32'h400, 32'h1,         32'h0,         1'b0, 3, 0);
        vecs[5]  = mk(0, 1'b0, 32'h0,   32'h0,         32'h1,         1'b0, 3, 0);
        vecs[6]  = mk(0, 1'b0, 32'h13,  32'h0,         MIS ? 32'h0 : 32'hDEAD_BEEF, MIS, 3, 0);
        vecs[7]  = mk(0, 1'b1, 32'h7FC, 32'h1234_5678, 32'h0,         1'b0, 3, 0);
        vecs[8]  = mk(0, 1'b0, 32'h3FC, 32'h0,         32'h1234_5678, 1'b0, 3, 0);
        vecs[9]  = mk(0, 1'b1, 32'h20,  32'hA5A5_0020, 32'h0,         1'b0, 3, 0);
        vecs[10] = mk(1, 1'b1, 32'h4,   32'h0BAD_F00D, 32'h0,         1'b0, 1, 0);
        vecs[11] = mk(1, 1'b0, 32'h4,   32'h0,         32'h0BAD_F00D, 1'b0, 1, 0);
        vecs[12] = mk(1, 1'b1, 32'h6,   32'hFEED_FACE, 32'h0,         MIS, 1, 2);
        vecs[13] = mk(1, 1'b0, 32'h4,   32'h0,         MIS ? 32'h0BAD_F00D : 32'hFEED_FACE, 1'b0, 1, 0);
        vecs[14] = mk(0, 1'b1, 32'h11,  32'hC0FF_EE11, 32'h0,         MIS, 3, 0);
        vecs[15] = mk(0, 1'b0, 32'h10,  32'h0,         MIS ? 32'hDEAD_BEEF : 32'hC0FF_EE11, 1'b0, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("reset%0d_valid", w), 32'(rsp_valid[w]), 32'd0);
            chk($sformatf("reset%0d_rdata", w), rsp_rdata[w], 32'h0);
            chk($sformatf("reset%0d_err", w), 32'(rsp_err[w]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset0_ready", 32'(req_ready[0]), 32'd1);
        chk("reset1_ready", 32'(req_ready[1]), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset pulse while a store to 0x20 is waiting: the store must be dropped.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write    = 1'b1;
        req_addr     = 32'h20;
        req_wdata    = 32'hFFFF_0000;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rstwait_busy", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstwait_ready", 32'(req_ready[0]), 32'd1);
        chk("rstwait_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rstwait_rdata", rsp_rdata[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rstwait_quiet%0d", c), 32'(rsp_valid[0]), 32'd0);
        end
        run_txn(mk(0, 1'b0, 32'h20, 32'h0, 32'hA5A5_0020, 1'b0, 3, 0), "rstwait_load");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
